// File: rtl/io_panel.sv
// rtl/io_panel.sv - bus-mapped LED / 7-segment front panel with per-digit blanking and blink
//
// Ports:
//   sys_clk   - system clock, all state on the rising edge
//   rst       - asynchronous active-low reset
//   bus_req   - transaction request, held until bus_ack is seen
//   bus_wren  - 1 = write, 0 = read, sampled with bus_req
//   bus_addr  - register word address (0 LED, 1 VAL, 2 EN, 3 BLINK, 4 STAT)
//   bus_wdata - write data
//   bus_rdata - read data, driven only while bus_ack is high
//   bus_ack   - one-cycle completion pulse
//   led_out   - LED drive, active-high
//   seg_out   - digit i on [7i+6:7i], segments g..a, active-low
module io_panel #(
    parameter int LED_W     = 10,
    parameter int NUM_SEG   = 6,
    parameter int BLINK_DIV = 25000000,
    parameter int ADDR_W    = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 bus_req,
    input  logic                 bus_wren,
    input  logic [ADDR_W-1:0]    bus_addr,
    input  logic [31:0]          bus_wdata,
    output logic [31:0]          bus_rdata,
    output logic                 bus_ack,
    output logic [LED_W-1:0]     led_out,
    output logic [7*NUM_SEG-1:0] seg_out
);

    localparam int VAL_W = 4 * NUM_SEG;
    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    localparam logic [ADDR_W-1:0] A_LED   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_VAL   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_EN    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_BLINK = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [LED_W-1:0]   led_q,   led_d;
    logic [VAL_W-1:0]   val_q,   val_d;
    logic [NUM_SEG-1:0] en_q,    en_d;
    logic [NUM_SEG-1:0] blink_q, blink_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [31:0]        rdata_q, rdata_d;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        val_d   = val_q;
        en_d    = en_q;
        blink_d = blink_q;
        rdata_d = rdata_q;

        // Free-running prescaler; bus traffic never touches it.
        if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus_req) begin
                    state_d = S_ACK;
                    rdata_d = '0;
                    if (bus_wren) begin
                        case (bus_addr)
                            A_LED:   led_d   = bus_wdata[LED_W-1:0];
                            A_VAL:   val_d   = bus_wdata[VAL_W-1:0];
                            A_EN:    en_d    = bus_wdata[NUM_SEG-1:0];
                            A_BLINK: blink_d = bus_wdata[NUM_SEG-1:0];
                            default: ;
                        endcase
                    end else begin
                        case (bus_addr)
                            A_LED:   rdata_d = 32'(led_q);
                            A_VAL:   rdata_d = 32'(val_q);
                            A_EN:    rdata_d = 32'(en_q);
                            A_BLINK: rdata_d = 32'(blink_q);
                            A_STAT:  rdata_d = {31'b0, phase_q};
                            default: rdata_d = '0;
                        endcase
                    end
                end
            end
            S_ACK:   state_d = S_WAIT;
            // A request still held after the ack must drop before another can start.
            S_WAIT:  if (!bus_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            led_q   <= '0;
            val_q   <= '0;
            en_q    <= '1;
            blink_q <= '0;
            phase_q <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            val_q   <= val_d;
            en_q    <= en_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_ack   = (state_q == S_ACK);
    assign bus_rdata = bus_ack ? rdata_q : 32'h0;
    assign led_out   = led_q;

    always_comb begin
        seg_out = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (!en_q[i] || (blink_q[i] && !phase_q)) begin
                seg_out[7*i +: 7] = 7'h7F;
            end else begin
                seg_out[7*i +: 7] = hex7(val_q[4*i +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_io_panel.sv
// tb/tb_io_panel.sv - self-checking bench for io_panel
module tb_io_panel;

    localparam int LED_W  = 10;
    localparam int NSEG   = 6;
    localparam int BD     = 4;
    localparam int ADDR_W = 4;

    logic              sys_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bus_req = 1'b0;
    logic              bus_wren = 1'b0;
    logic [ADDR_W-1:0] bus_addr = '0;
    logic [31:0]       bus_wdata = '0;
    logic [31:0]       bus_rdata;
    logic              bus_ack;
    logic [LED_W-1:0]  led_out;
    logic [7*NSEG-1:0] seg_out;

    io_panel #(.LED_W(LED_W), .NUM_SEG(NSEG), .BLINK_DIV(BD), .ADDR_W(ADDR_W)) dut (
        .sys_clk(sys_clk), .rst(rst_n), .bus_req(bus_req), .bus_wren(bus_wren),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .led_out(led_out), .seg_out(seg_out)
    );

    always #5 sys_clk = ~sys_clk;

    // Edges seen since reset release; the blink phase is a pure function of this.
    int edges;
    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    int checks = 0;
    int errors = 0;

    // Reference register state
    logic [9:0]  m_led;
    logic [23:0] m_val;
    logic [5:0]  m_en;
    logic [5:0]  m_blink;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_phase(input int e);
        return ((e / BD) % 2) == 0;
    endfunction

    function automatic logic [41:0] exp_seg(input int e);
        logic [41:0] s;
        logic [3:0]  nib;
        s = '0;
        for (int i = 0; i < NSEG; i++) begin
            nib = m_val[4*i +: 4];
            if (!m_en[i] || (m_blink[i] && !exp_phase(e))) s[7*i +: 7] = 7'h7F;
            else                                           s[7*i +: 7] = hex_tab[nib];
        end
        return s;
    endfunction

    task automatic model_reset();
        m_led = '0; m_val = '0; m_en = '1; m_blink = '0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] wd);
        case (a)
            4'd0: m_led   = wd[9:0];
            4'd1: m_val   = wd[23:0];
            4'd2: m_en    = wd[5:0];
            4'd3: m_blink = wd[5:0];
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a, input int e_before);
        case (a)
            4'd0: return {22'b0, m_led};
            4'd1: return {8'b0, m_val};
            4'd2: return {26'b0, m_en};
            4'd3: return {26'b0, m_blink};
            4'd4: return {31'b0, exp_phase(e_before)};
            default: return 32'h0;
        endcase
    endfunction

    // One full four-phase transaction; checks ack timing, rdata and outputs in cycle N+1.
    task automatic bus_xfer(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                            output logic [31:0] rd);
        @(negedge sys_clk);
        bus_req = 1'b1; bus_wren = wr; bus_addr = a; bus_wdata = wd;
        @(negedge sys_clk);
        check("ack_at_n1", bus_ack, 1);
        rd = bus_rdata;
        if (wr) model_write(a, wd);
        else    check("rdata_model", rd, model_read(a, edges - 1));
        check("led_at_n1", led_out, m_led);
        check("seg_at_n1", seg_out, exp_seg(edges));
        @(negedge sys_clk);
        check("ack_one_cycle", bus_ack, 0);
        check("rdata_zero_no_ack", bus_rdata, 0);
        bus_req = 1'b0;
        @(negedge sys_clk);
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [9:0]  exp_led;
        logic [41:0] exp_seg;
    } vec_t;

    localparam logic [41:0] SEG_A  = {7'h08, 7'h12, 7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [41:0] SEG_E5 = {7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h7F, 7'h19};

    vec_t tbl [12];

    initial begin
        logic [31:0] rd;
        logic [6:0]  d0_prev;
        int          toggles;
        int          acks;

        tbl[0]  = '{1'b1, 4'd1, 32'h00A5_1234, 1'b0, 32'h0,         10'h000, SEG_A};
        tbl[1]  = '{1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0, 32'h0,         10'h3FF, SEG_A};
        tbl[2]  = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h0000_03FF, 10'h3FF, SEG_A};
        tbl[3]  = '{1'b0, 4'd1, 32'h0,         1'b1, 32'h00A5_1234, 10'h3FF, SEG_A};
        tbl[4]  = '{1'b1, 4'd2, 32'h0000_0005, 1'b0, 32'h0,         10'h3FF, SEG_E5};
        tbl[5]  = '{1'b0, 4'd2, 32'h0,         1'b1, 32'h0000_0005, 10'h3FF, SEG_E5};
        tbl[6]  = '{1'b1, 4'd2, 32'hFFFF_FFFF, 1'b0, 32'h0,         10'h3FF, SEG_A};
        tbl[7]  = '{1'b0, 4'd2, 32'h0,         1'b1, 32'h0000_003F, 10'h3FF, SEG_A};
        tbl[8]  = '{1'b0, 4'd9, 32'h0,         1'b1, 32'h0,         10'h3FF, SEG_A};
        tbl[9]  = '{1'b1, 4'd3, 32'hFFFF_FFC0, 1'b0, 32'h0,         10'h3FF, SEG_A};
        tbl[10] = '{1'b0, 4'd3, 32'h0,         1'b1, 32'h0,         10'h3FF, SEG_A};
        tbl[11] = '{1'b1, 4'd0, 32'h0,         1'b0, 32'h0,         10'h000, SEG_A};

        // Reset state
        model_reset();
        repeat (3) @(negedge sys_clk);
        check("rst_led", led_out, 0);
        check("rst_seg", seg_out, {6{7'h40}});
        check("rst_ack", bus_ack, 0);
        check("rst_rdata", bus_rdata, 0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("post_rst_seg", seg_out, {6{7'h40}});

        // Directed register vectors
        for (int i = 0; i < 12; i++) begin
            bus_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd);
            if (tbl[i].chk_rd) check("tbl_rdata", rd, tbl[i].exp_rd);
            check("tbl_led", led_out, tbl[i].exp_led);
            check("tbl_seg", seg_out, tbl[i].exp_seg);
        end

        // Blink: digit 0 alternates every BD cycles, the rest hold steady
        bus_xfer(1'b1, 4'd2, 32'h3F, rd);
        bus_xfer(1'b1, 4'd3, 32'h01, rd);
        d0_prev = seg_out[6:0];
        toggles = 0;
        for (int c = 0; c < 4 * BD; c++) begin
            @(negedge sys_clk);
            check("blink_seg", seg_out, exp_seg(edges));
            check("blink_steady", seg_out[41:7], SEG_A[41:7]);
            if (seg_out[6:0] != d0_prev) toggles++;
            d0_prev = seg_out[6:0];
        end
        check("blink_toggles", toggles, 4);

        // Held request gives exactly one ack
        @(negedge sys_clk);
        bus_req = 1'b1; bus_wren = 1'b0; bus_addr = 4'd0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            if (bus_ack) acks++;
        end
        bus_req = 1'b0;
        @(negedge sys_clk);
        check("held_req_acks", acks, 1);

        // STAT is read-only
        bus_xfer(1'b1, 4'd4, 32'hFFFF_FFFF, rd);
        bus_xfer(1'b0, 4'd4, 32'h0, rd);
        bus_xfer(1'b0, 4'd9, 32'h0, rd);
        check("unmapped_read", rd, 0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            bus_xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), $urandom, rd);
            repeat ($urandom_range(0, 5)) begin
                @(negedge sys_clk);
                check("rand_seg", seg_out, exp_seg(edges));
                check("rand_led", led_out, m_led);
            end
        end

        // Reset during the ACK cycle
        @(negedge sys_clk);
        bus_req = 1'b1; bus_wren = 1'b1; bus_addr = 4'd0; bus_wdata = 32'h155;
        @(negedge sys_clk);
        check("pre_rst_ack", bus_ack, 1);
        check("pre_rst_led", led_out, 10'h155);
        rst_n = 1'b0;
        #1;
        check("async_ack_drop", bus_ack, 0);
        check("async_led", led_out, 0);
        check("async_seg", seg_out, {6{7'h40}});
        check("async_rdata", bus_rdata, 0);
        model_reset();
        bus_req = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        bus_xfer(1'b0, 4'd2, 32'h0, rd);
        check("after_rst_en", rd, 32'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
